// File: rtl/retime_pkg.sv
// Sizing helpers shared by the pipeline-head issuer and the tail sink, so both
// sides build credit/occupancy counters of identical width.
package retime_pkg;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_retime_sink_fifo.sv
// Circular buffer with first-word fall-through read and an occupancy counter.
// Writes land one cycle before they are visible; caller guarantees no overflow or underflow.
module dff_retime_sink_fifo
  import retime_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          head_data,
  output logic [cnt_w(DEPTH)-1:0]   occ
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    occ_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    occ_next = occ;
    if (push && !pop) occ_next = occ + CW'(1);
    else if (pop && !push) occ_next = occ - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      occ <= occ_next;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Storage carries no reset; occ alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && occ == CW'(DEPTH)));
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && occ == '0));

endmodule

// File: rtl/dff_retime_sink.sv
// Credit-managed tail buffer for a stall-free pipeline: arrival to out_valid_o is 1 cycle.
// Backpressure is pushed upstream as withheld issue credits; ready_up_o depends on registers only.
module dff_retime_sink
  import retime_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int PIPE_DEPTH = 1,
  parameter int FIFO_DEPTH = PIPE_DEPTH + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_i,
  output logic             ready_up_o,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic             err_o
);

  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [CW-1:0] occ;
  logic [CW-1:0] inflight;
  logic [CW-1:0] inflight_next;
  logic [CW:0]   credit_used;
  logic          err;
  logic          pop;
  logic          arrive;
  logic          overflow;
  logic          push;
  logic          stray;
  logic          bad_issue;

  // One extra bit so occ + inflight cannot wrap before the compare.
  assign credit_used = {1'b0, occ} + {1'b0, inflight};
  assign ready_up_o  = rst_n & (credit_used < {1'b0, FULL_CNT});

  assign out_valid_o = rst_n & (occ != '0);
  assign pop         = out_valid_o & out_ready_i;

  assign arrive    = in_valid_i & (inflight != '0);
  assign overflow  = arrive & (occ == FULL_CNT) & ~pop;
  assign push      = arrive & ~overflow;
  assign stray     = in_valid_i & (inflight == '0);
  assign bad_issue = issue_i & ~ready_up_o;

  // An illegal issue is still counted so the later arrival is not also flagged stray.
  always_comb begin
    inflight_next = inflight;
    if (issue_i && !arrive) begin
      if (inflight != FULL_CNT) inflight_next = inflight + CW'(1);
    end else if (arrive && !issue_i) begin
      inflight_next = inflight - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= '0;
      err      <= 1'b0;
    end else begin
      inflight <= inflight_next;
      if (bad_issue || stray || overflow) err <= 1'b1;
    end
  end

  assign err_o = rst_n & err;

  dff_retime_sink_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_data_i),
    .pop       (pop),
    .head_data (out_data_o),
    .occ       (occ)
  );

  a_inflight_bound : assert property (@(posedge clk) disable iff (!rst_n)
    inflight <= FULL_CNT);

endmodule
